// File: rtl/t_toggle_counter.sv
`default_nettype none
// ============================================================================
//  Module   : t_toggle_counter
//  Purpose  : Dual-personality register of WIDTH bits.
//             mode=0 (COUNT)  : synchronous up/down counter over 0..MAX_COUNT,
//                               wrapping (SATURATE=0) or holding (SATURATE=1)
//                               at the boundaries.
//             mode=1 (TOGGLE) : bank of WIDTH independent T flip-flops,
//                               q <= q ^ t when en is high.
//             A synchronous parallel load has priority over counting/toggling;
//             a synchronous active-low reset has priority over everything.
//  Ports    : clk      - rising-edge clock
//             reset    - synchronous reset, active low
//             mode     - 0 = COUNT, 1 = TOGGLE
//             en       - count enable / global toggle enable
//             up       - count direction (1 = up), COUNT mode only
//             t        - per-bit toggle requests, TOGGLE mode only
//             load     - parallel load strobe
//             load_val - value written on load (clamped in COUNT mode)
//             q        - registered state
//             tc       - combinational terminal-count flag (COUNT mode only)
//             wrap     - registered one-cycle pulse after a boundary crossing
//  Revision : 1.0 - initial release
// ============================================================================
module t_toggle_counter #(
    parameter int WIDTH     = 3,   // register width, 1..16
    parameter int MAX_COUNT = 7,   // top of the count range, 1..2^WIDTH-1
    parameter int SATURATE  = 0    // 0 = wrap at boundaries, 1 = hold
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mode,
    input  logic             en,
    input  logic             up,
    input  logic [WIDTH-1:0] t,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] c_MAX  = WIDTH'(MAX_COUNT);
    localparam logic [WIDTH-1:0] c_ZERO = '0;
    localparam logic             c_SAT  = (SATURATE != 0);

    logic [WIDTH-1:0] r_q;
    logic             r_wrap;

    logic [WIDTH-1:0] w_q_eff;
    logic [WIDTH-1:0] w_load_clamped;
    logic [WIDTH-1:0] w_inc;
    logic [WIDTH-1:0] w_dec;
    logic [WIDTH-1:0] w_count_next;
    logic [WIDTH-1:0] w_toggle_next;
    logic [WIDTH-1:0] w_load_next;
    logic             w_at_top;
    logic             w_at_bot;
    logic             w_tc;
    logic             w_wrap_next;

    // ------------------------------------------------------------------
    // Boundary detection. A value above MAX_COUNT can be left behind by
    // TOGGLE mode; COUNT mode treats it as sitting on the top boundary,
    // so the ">=" comparison is intentional.
    // ------------------------------------------------------------------
    assign w_at_top = (r_q >= c_MAX);
    assign w_at_bot = (r_q == c_ZERO);

    // Terminal count ignores en so software can see the boundary coming.
    assign w_tc = ~mode & (up ? w_at_top : w_at_bot);

    // Effective count value with out-of-range state folded onto MAX_COUNT.
    assign w_q_eff = w_at_top ? c_MAX : r_q;

    assign w_inc = w_q_eff + 1'b1;
    assign w_dec = w_q_eff - 1'b1;

    always_comb begin
        w_count_next = w_q_eff;
        if (up) begin
            if (w_at_top) begin
                w_count_next = c_SAT ? c_MAX : c_ZERO;
            end else begin
                w_count_next = w_inc;
            end
        end else begin
            if (w_at_bot) begin
                w_count_next = c_SAT ? c_ZERO : c_MAX;
            end else begin
                w_count_next = w_dec;
            end
        end
    end

    assign w_toggle_next = r_q ^ t;

    // COUNT-mode loads are clamped into the legal range; TOGGLE-mode loads
    // accept any bit pattern.
    assign w_load_clamped = (load_val > c_MAX) ? c_MAX : load_val;
    assign w_load_next    = mode ? load_val : w_load_clamped;

    // A wrap only happens when the counter actually advances across a
    // boundary: load suppresses it, and saturating builds never wrap.
    // w_tc already implies COUNT mode.
    assign w_wrap_next = en & ~load & w_tc & ~c_SAT;

    // ------------------------------------------------------------------
    // State register: reset, then load, then en, then hold.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_q    <= c_ZERO;
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= w_wrap_next;
            if (load) begin
                r_q <= w_load_next;
            end else if (en) begin
                r_q <= mode ? w_toggle_next : w_count_next;
            end
        end
    end

    assign q    = r_q;
    assign tc   = w_tc;
    assign wrap = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_t_toggle_counter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_t_toggle_counter
//  Purpose  : Self-checking bench for t_toggle_counter. Three instances share
//             one stimulus stream:
//               u0 : WIDTH=3, MAX_COUNT=7, SATURATE=0
//               u1 : WIDTH=3, MAX_COUNT=7, SATURATE=1
//               u2 : WIDTH=3, MAX_COUNT=5, SATURATE=0
//             A vector table covers reset and the basic up-count, hand
//             sequences cover the multi-cycle corners, and a random phase is
//             compared against an arithmetic reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_t_toggle_counter;

    logic       clk;
    logic       reset;
    logic       mode;
    logic       en;
    logic       up;
    logic [2:0] t;
    logic       load;
    logic [2:0] load_val;

    logic [2:0] q0, q1, q2;
    logic       tc0, tc1, tc2;
    logic       wrap0, wrap1, wrap2;

    int n_checks = 0;
    int n_pass   = 0;

    t_toggle_counter #(.WIDTH(3), .MAX_COUNT(7), .SATURATE(0)) u0 (
        .clk(clk), .reset(reset), .mode(mode), .en(en), .up(up), .t(t),
        .load(load), .load_val(load_val), .q(q0), .tc(tc0), .wrap(wrap0));

    t_toggle_counter #(.WIDTH(3), .MAX_COUNT(7), .SATURATE(1)) u1 (
        .clk(clk), .reset(reset), .mode(mode), .en(en), .up(up), .t(t),
        .load(load), .load_val(load_val), .q(q1), .tc(tc1), .wrap(wrap1));

    t_toggle_counter #(.WIDTH(3), .MAX_COUNT(5), .SATURATE(0)) u2 (
        .clk(clk), .reset(reset), .mode(mode), .en(en), .up(up), .t(t),
        .load(load), .load_val(load_val), .q(q2), .tc(tc2), .wrap(wrap2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int MXS  [3] = '{7, 7, 5};
    bit SATS [3] = '{1'b0, 1'b1, 1'b0};
    int mq   [3];
    bit mw   [3];

    function automatic bit m_tc(input int i);
        if (mode) return 1'b0;
        if (up)   return (mq[i] >= MXS[i]);
        return (mq[i] == 0);
    endfunction

    function automatic int m_next(input int i);
        int e;
        if (!reset) return 0;
        if (load) begin
            if (mode) return int'(load_val);
            return (int'(load_val) > MXS[i]) ? MXS[i] : int'(load_val);
        end
        if (!en) return mq[i];
        if (mode) return mq[i] ^ int'(t);
        e = (mq[i] > MXS[i]) ? MXS[i] : mq[i];
        if (up) begin
            if (e == MXS[i]) return SATS[i] ? MXS[i] : 0;
            return e + 1;
        end
        if (e == 0) return SATS[i] ? 0 : MXS[i];
        return e - 1;
    endfunction

    // Apply current inputs across one rising edge, advance the model, and
    // leave the caller #1 after the edge with inputs still stable.
    task automatic step();
        int nq [3];
        bit nw [3];
        for (int i = 0; i < 3; i++) begin
            nq[i] = m_next(i);
            nw[i] = reset && !load && en && m_tc(i) && !SATS[i];
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            mq[i] = nq[i];
            mw[i] = nw[i];
        end
    endtask

    task automatic drive(input logic r, input logic m, input logic e,
                         input logic u, input logic [2:0] tv,
                         input logic l, input logic [2:0] lv);
        reset = r; mode = m; en = e; up = u; t = tv; load = l; load_val = lv;
    endtask

    task automatic chk(input string name, input logic [2:0] got,
                       input logic [2:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    task automatic chk3(input string name, input logic [2:0] gq,
                        input logic gtc, input logic gw,
                        input logic [2:0] eq, input logic etc, input logic ew);
        chk({name, ".q"},    gq,          eq);
        chk({name, ".tc"},   {2'b0, gtc}, {2'b0, etc});
        chk({name, ".wrap"}, {2'b0, gw},  {2'b0, ew});
    endtask

    // ---------------- vector table (u0) ----------------
    typedef struct {
        logic       r, m, e, u, l;
        logic [2:0] tv, lv;
        logic [2:0] eq;
        logic       etc, ew;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic m, input logic e,
                                input logic u, input logic [2:0] tv,
                                input logic l, input logic [2:0] lv,
                                input logic [2:0] eq, input logic etc,
                                input logic ew);
        vec_t v;
        v.r = r; v.m = m; v.e = e; v.u = u; v.tv = tv; v.l = l; v.lv = lv;
        v.eq = eq; v.etc = etc; v.ew = ew;
        return v;
    endfunction

    vec_t vt [11];

    initial begin
        // Two reset edges with a competing load of 5, then 9 up-count edges.
        vt[0]  = mk(0, 0, 1, 0, 3'd0, 1, 3'd5, 3'd0, 1, 0);
        vt[1]  = mk(0, 0, 1, 0, 3'd0, 1, 3'd5, 3'd0, 1, 0);
        vt[2]  = mk(1, 0, 1, 1, 3'd0, 0, 3'd0, 3'd1, 0, 0);
        vt[3]  = mk(1, 0, 1, 1, 3'd0, 0, 3'd0, 3'd2, 0, 0);
        vt[4]  = mk(1, 0, 1, 1, 3'd0, 0, 3'd0, 3'd3, 0, 0);
        vt[5]  = mk(1, 0, 1, 1, 3'd0, 0, 3'd0, 3'd4, 0, 0);
        vt[6]  = mk(1, 0, 1, 1, 3'd0, 0, 3'd0, 3'd5, 0, 0);
        vt[7]  = mk(1, 0, 1, 1, 3'd0, 0, 3'd0, 3'd6, 0, 0);
        vt[8]  = mk(1, 0, 1, 1, 3'd0, 0, 3'd0, 3'd7, 1, 0);
        vt[9]  = mk(1, 0, 1, 1, 3'd0, 0, 3'd0, 3'd0, 0, 1);
        vt[10] = mk(1, 0, 1, 1, 3'd0, 0, 3'd0, 3'd1, 0, 0);

        drive(0, 0, 0, 0, 3'd0, 0, 3'd0);
        for (int i = 0; i < 3; i++) begin mq[i] = 0; mw[i] = 0; end
        #2;

        for (int i = 0; i < 11; i++) begin
            drive(vt[i].r, vt[i].m, vt[i].e, vt[i].u, vt[i].tv, vt[i].l, vt[i].lv);
            step();
            chk3($sformatf("vec%0d", i), q0, tc0, wrap0, vt[i].eq, vt[i].etc, vt[i].ew);
        end

        // Down from 0: u0 wraps to 7, saturating u1 holds 0 with tc high.
        drive(0, 0, 1, 0, 3'd0, 0, 3'd0); step();
        drive(1, 0, 1, 0, 3'd0, 0, 3'd0); step();
        chk3("down_wrap_u0", q0, tc0, wrap0, 3'd7, 0, 1);
        chk3("down_sat_u1",  q1, tc1, wrap1, 3'd0, 1, 0);
        step();
        chk3("down2_u0", q0, tc0, wrap0, 3'd6, 0, 0);
        chk3("down2_u1", q1, tc1, wrap1, 3'd0, 1, 0);

        // Clamped load on MAX_COUNT=5, then wrap on the next up edge.
        drive(1, 0, 0, 1, 3'd0, 1, 3'd7); step();
        chk3("load_clamp_u2", q2, tc2, wrap2, 3'd5, 1, 0);
        chk3("load_u0",       q0, tc0, wrap0, 3'd7, 1, 0);
        drive(1, 0, 1, 1, 3'd0, 0, 3'd0); step();
        chk3("clamp_wrap_u2", q2, tc2, wrap2, 3'd0, 0, 1);
        // Load coinciding with a boundary suppresses wrap.
        drive(1, 0, 0, 1, 3'd0, 1, 3'd7); step();
        drive(1, 0, 1, 1, 3'd0, 1, 3'd2); step();
        chk3("load_beats_wrap_u0", q0, tc0, wrap0, 3'd2, 0, 0);

        // TOGGLE mode from 000 with t=101.
        drive(0, 1, 0, 0, 3'd0, 0, 3'd0); step();
        drive(1, 1, 1, 0, 3'b101, 0, 3'd0); step();
        chk3("tog1", q0, tc0, wrap0, 3'b101, 0, 0);
        step();
        chk3("tog2", q0, tc0, wrap0, 3'b000, 0, 0);
        drive(1, 1, 0, 0, 3'b101, 0, 3'd0); step();
        chk3("tog_hold0", q0, tc0, wrap0, 3'b000, 0, 0);
        drive(1, 1, 1, 0, 3'b101, 0, 3'd0); step();
        drive(1, 1, 0, 0, 3'b111, 0, 3'd0); step();
        chk3("tog_hold5", q0, tc0, wrap0, 3'b101, 0, 0);

        // Out-of-range state on u2 (q=7, MAX=5) after a mode switch.
        drive(1, 1, 0, 0, 3'd0, 1, 3'd7); step();
        chk("tog_load7_u2", q2, 3'd7);
        drive(1, 0, 0, 1, 3'd0, 0, 3'd0); #1;
        chk("oor_tc_u2", {2'b0, tc2}, 3'd1);
        drive(1, 0, 1, 0, 3'd0, 0, 3'd0); step();
        chk3("oor_down_u2", q2, tc2, wrap2, 3'd4, 0, 0);

        // Mid-count reset at q=4, then resume from 0.
        drive(0, 0, 0, 1, 3'd0, 0, 3'd0); step();
        drive(1, 0, 1, 1, 3'd0, 0, 3'd0);
        for (int i = 0; i < 4; i++) step();
        chk("pre_reset_q4", q0, 3'd4);
        drive(0, 0, 1, 1, 3'd0, 0, 3'd0); step();
        chk3("mid_reset", q0, tc0, wrap0, 3'd0, 0, 0);
        drive(1, 0, 1, 1, 3'd0, 0, 3'd0); step();
        chk3("resume", q0, tc0, wrap0, 3'd1, 0, 0);

        // Random phase against the reference model.
        for (int n = 0; n < 400; n++) begin
            drive(($urandom_range(0, 24) != 0), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                  3'($urandom_range(0, 7)), ($urandom_range(0, 7) == 0),
                  3'($urandom_range(0, 7)));
            step();
            chk3($sformatf("rnd%0d_u0", n), q0, tc0, wrap0, 3'(mq[0]), m_tc(0), mw[0]);
            chk3($sformatf("rnd%0d_u1", n), q1, tc1, wrap1, 3'(mq[1]), m_tc(1), mw[1]);
            chk3($sformatf("rnd%0d_u2", n), q2, tc2, wrap2, 3'(mq[2]), m_tc(2), mw[2]);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/t_toggle_counter.md
T_TOGGLE_COUNTER -- requirements
Module: t_toggle_counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 3, meaning the register width in bits (valid range 1..16).
REQ-002 The block SHALL have parameter MAX_COUNT, default 7, meaning the highest count value in COUNT mode (valid range 1..2^WIDTH-1).
REQ-003 The block SHALL have parameter SATURATE, default 0, where 0 means wrap at the count boundaries and 1 means hold at the boundary.
REQ-004 The block SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-low reset, sampled on the rising edge of clk.
REQ-006 The block SHALL have port mode, input, 1 bit: 0 = COUNT (synchronous up/down counter), 1 = TOGGLE (bank of WIDTH independent T flip-flops).
REQ-007 The block SHALL have port en, input, 1 bit: count enable in COUNT mode, global toggle enable in TOGGLE mode.
REQ-008 The block SHALL have port up, input, 1 bit: count direction in COUNT mode (1 = up, 0 = down); ignored in TOGGLE mode.
REQ-009 The block SHALL have port t, input, WIDTH bits: per-bit toggle requests in TOGGLE mode; ignored in COUNT mode.
REQ-010 The block SHALL have port load, input, 1 bit: synchronous parallel load strobe.
REQ-011 The block SHALL have port load_val, input, WIDTH bits: the value written on load.
REQ-012 The block SHALL have port q, output, WIDTH bits: registered state.
REQ-013 The block SHALL have port tc, output, 1 bit: combinational terminal-count flag.
REQ-014 The block SHALL have port wrap, output, 1 bit: registered one-cycle pulse on a boundary crossing.

Function
REQ-015 The block SHALL apply this per-edge priority: reset low, then load, then en, then hold.
REQ-016 The block SHALL, on load, set q to load_val in both modes; in COUNT mode it SHALL clamp a load_val above MAX_COUNT to MAX_COUNT.
REQ-017 The block SHALL, in TOGGLE mode with en=1 and load=0, set q to q XOR t on each edge; bits with t=0 hold their value.
REQ-018 The block SHALL, in TOGGLE mode with en=0, hold q.
REQ-019 The block SHALL, in COUNT mode with up=1 and en=1, increment q by 1, and on q=MAX_COUNT set q to 0 (SATURATE=0) or hold MAX_COUNT (SATURATE=1).
REQ-020 The block SHALL, in COUNT mode with up=0 and en=1, decrement q by 1, and on q=0 set q to MAX_COUNT (SATURATE=0) or hold 0 (SATURATE=1).
REQ-021 The block SHALL, in COUNT mode, treat any q above MAX_COUNT (reachable via a mode switch) as MAX_COUNT when computing the next count value.
REQ-022 The block SHALL drive tc=1 only when mode=0 and either (up=1 and q>=MAX_COUNT) or (up=0 and q=0), independent of en.
REQ-023 The block SHALL set wrap=1 for exactly the one cycle following an edge where mode=0, en=1, load=0, tc=1 and SATURATE=0; otherwise wrap SHALL be 0.
REQ-024 The block SHALL NOT assert wrap when load and a boundary coincide, because load wins.
REQ-025 The block SHALL apply a change of mode or up on the same edge at which it is sampled, with no pipeline delay, and SHALL carry q over unchanged.
REQ-026 The block SHALL have a latency of 1 clk edge from any input to q and to wrap, and 0 cycles from q/mode/up to tc.

Reset
REQ-027 The block SHALL, when reset=0 at a rising edge, set q=0 and wrap=0 regardless of all other inputs, including load.
REQ-028 The block SHALL produce tc during and after reset as defined by REQ-022 (tc=1 when mode=0 and up=0).
REQ-029 The block SHALL abandon any count or toggle in progress on a mid-operation reset, and counting SHALL resume from 0 at the first edge with reset=1.
REQ-030 The block SHALL leave q undefined before the first reset edge; benches SHALL apply reset for at least 1 edge.

Verification (WIDTH=3, MAX_COUNT=7 unless noted)
REQ-031 The bench SHALL check that reset=0 for 2 edges with load=1 and load_val=5 gives q=0, wrap=0.
REQ-032 The bench SHALL check that COUNT mode with up=1 and en=1 for 9 edges from q=0 gives q=1..7,0,1, with wrap high only in the cycle after the 7->0 edge, and tc=1 while q=7.
REQ-033 The bench SHALL check that COUNT mode with up=0 from q=0 gives q=7 and a wrap pulse; with SATURATE=1 and the same stimulus it gives q=0 held, tc=1, wrap=0.
REQ-034 The bench SHALL check that, with MAX_COUNT=5, load=1 and load_val=7 give q=5, and that the next up-count edge gives q=0 with wrap=1.
REQ-035 The bench SHALL check that TOGGLE mode with q=3'b000 and t=3'b101, en=1 for 2 edges gives q=101 then 000, and that en=0 holds q.
REQ-036 The bench SHALL check that reset=0 asserted mid-count at q=4 gives q=0 on that edge, and that release with en=1 and up=1 gives q=1 on the next edge.
